// File: rtl/tag_ctrl.sv
`default_nettype none
// ============================================================================
// tag_ctrl : valid-bit store and tag-RAM sequencing for a direct-mapped cache
// Rev 1.0
// ============================================================================
module tag_ctrl #(
    parameter int TAG_WIDTH   = 20,
    parameter int INDEX_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lkp_valid_i,
    output logic                   lkp_ready_o,
    input  logic [INDEX_WIDTH-1:0] lkp_index_i,
    input  logic [TAG_WIDTH-1:0]   lkp_tag_i,
    output logic                   resp_valid_o,
    output logic                   resp_hit_o,
    input  logic                   rfl_valid_i,
    output logic                   rfl_ready_o,
    input  logic [INDEX_WIDTH-1:0] rfl_index_i,
    input  logic [TAG_WIDTH-1:0]   rfl_tag_i,
    input  logic                   flush_req_i,
    output logic                   flush_busy_o,
    output logic                   flush_done_o,
    output logic [INDEX_WIDTH-1:0] ram_index_o,
    output logic                   ram_wr_en_o,
    output logic [TAG_WIDTH-1:0]   ram_wr_tag_o,
    input  logic [TAG_WIDTH-1:0]   ram_rd_tag_i
);
    localparam int SETS = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [SETS-1:0]        valid;
    logic [INDEX_WIDTH-1:0] cnt;
    logic [INDEX_WIDTH-1:0] cap_index;
    logic [TAG_WIDTH-1:0]   cap_tag;
    logic                   idle_live, flush_go, rfl_acc, lkp_acc, cnt_last;

    // Gating with rst_n keeps every output low while reset is held.
    assign idle_live = rst_n && (state == IDLE);
    assign flush_go  = idle_live && flush_req_i;
    assign rfl_acc   = idle_live && !flush_req_i && rfl_valid_i;
    assign lkp_acc   = idle_live && !flush_req_i && !rfl_valid_i && lkp_valid_i;
    assign cnt_last  = &cnt;

    always_comb begin
        state_nxt    = state;
        lkp_ready_o  = 1'b0;
        rfl_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_hit_o   = 1'b0;
        flush_busy_o = 1'b0;
        flush_done_o = 1'b0;
        ram_index_o  = '0;
        ram_wr_en_o  = 1'b0;
        ram_wr_tag_o = '0;
        case (state)
            IDLE: begin
                lkp_ready_o = idle_live && !flush_req_i && !rfl_valid_i;
                rfl_ready_o = idle_live && !flush_req_i;
                if (flush_go) begin
                    state_nxt = FLUSH;
                end else if (rfl_acc) begin
                    ram_index_o  = rfl_index_i;
                    ram_wr_en_o  = 1'b1;
                    ram_wr_tag_o = rfl_tag_i;
                end else if (lkp_acc) begin
                    ram_index_o = lkp_index_i;
                    state_nxt   = LOOKUP;
                end
            end
            LOOKUP: begin
                resp_valid_o = 1'b1;
                resp_hit_o   = valid[cap_index] && (ram_rd_tag_i == cap_tag);
                state_nxt    = IDLE;
            end
            FLUSH: begin
                flush_busy_o = 1'b1;
                flush_done_o = cnt_last;
                ram_index_o  = cnt;
                ram_wr_en_o  = 1'b1;
                if (cnt_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_index <= '0;
            cap_tag   <= '0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH) begin
                cnt <= cnt_last ? '0 : cnt + 1'b1;
            end else if (flush_go) begin
                cnt <= '0;
            end
            if (lkp_acc) begin
                cap_index <= lkp_index_i;
                cap_tag   <= lkp_tag_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (state == FLUSH) begin
            valid[cnt] <= 1'b0;
        end else if (rfl_acc) begin
            valid[rfl_index_i] <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: doc/tag_ctrl.md
TAG_CTRL -- requirements
Module: tag_ctrl

Interface
REQ-001 SHALL have parameters: TAG_WIDTH, default 20, tag width; INDEX_WIDTH, default 8, index width (256 sets).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports lkp_valid_i, input, 1, and lkp_ready_o, output, 1: lookup request handshake.
REQ-005 SHALL have ports lkp_index_i, input, INDEX_WIDTH, and lkp_tag_i, input, TAG_WIDTH: lookup set and compare tag.
REQ-006 SHALL have ports resp_valid_o, output, 1, and resp_hit_o, output, 1: lookup result.
REQ-007 SHALL have ports rfl_valid_i, input, 1, and rfl_ready_o, output, 1: refill write handshake.
REQ-008 SHALL have ports rfl_index_i, input, INDEX_WIDTH, and rfl_tag_i, input, TAG_WIDTH: refill set and new tag.
REQ-009 SHALL have ports flush_req_i, input, 1, flush_busy_o, output, 1, and flush_done_o, output, 1: invalidate-all control.
REQ-010 SHALL have tag RAM ports ram_index_o, output, INDEX_WIDTH; ram_wr_en_o, output, 1; ram_wr_tag_o, output, TAG_WIDTH; ram_rd_tag_i, input, TAG_WIDTH (synchronous read, 1-cycle latency).

Function
REQ-011 SHALL keep one valid bit per set (2^INDEX_WIDTH bits) in internal registers.
REQ-012 SHALL implement states IDLE, LOOKUP, FLUSH.
REQ-013 SHALL prioritise in IDLE: flush_req_i > rfl_valid_i > lkp_valid_i.
REQ-014 SHALL drive lkp_ready_o=1 only in IDLE with flush_req_i=0 and rfl_valid_i=0.
REQ-015 SHALL drive rfl_ready_o=1 only in IDLE with flush_req_i=0.
REQ-016 SHALL, on lookup accept (cycle N), drive ram_index_o=lkp_index_i, ram_wr_en_o=0, capture index and tag, enter LOOKUP.
REQ-017 SHALL, in LOOKUP (cycle N+1), assert resp_valid_o for exactly one cycle with resp_hit_o = valid[captured index] AND (ram_rd_tag_i == captured tag), then return to IDLE.
REQ-018 SHALL hold resp_hit_o=0 whenever resp_valid_o=0.
REQ-019 SHALL sustain at most one lookup per two cycles; no requests accepted in LOOKUP.
REQ-020 SHALL, on refill accept, drive ram_index_o=rfl_index_i, ram_wr_en_o=1, ram_wr_tag_o=rfl_tag_i in the same cycle and set valid[rfl_index_i] at that edge; state stays IDLE.
REQ-021 SHALL allow back-to-back refills, one per cycle.
REQ-022 SHALL, on flush_req_i=1 in IDLE, enter FLUSH with sweep counter=0; flush_req_i is ignored in LOOKUP and FLUSH (no queueing).
REQ-023 SHALL, in FLUSH, each cycle drive ram_index_o=counter, ram_wr_en_o=1, ram_wr_tag_o=0, clear valid[counter], increment counter.
REQ-024 SHALL assert flush_busy_o throughout FLUSH and flush_done_o for one cycle on the cycle counter equals 2^INDEX_WIDTH-1, then return to IDLE; sweep takes exactly 2^INDEX_WIDTH cycles.
REQ-025 SHALL hold counter width INDEX_WIDTH; terminal detection on all-ones, no wrap past it.
REQ-026 SHALL drive ram_wr_en_o=0 and ram_wr_tag_o=0 when no write occurs; ram_index_o=0 when idle with no accept.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously enter IDLE, clear all valid bits, counter and captured fields to 0.
REQ-028 SHALL reset outputs: lkp_ready_o=0, rfl_ready_o=0, resp_valid_o=0, resp_hit_o=0, flush_busy_o=0, flush_done_o=0, ram_wr_en_o=0, ram_index_o=0, ram_wr_tag_o=0 while rst_n=0.
REQ-029 SHALL treat reset during FLUSH or LOOKUP as abort: no flush_done_o, no resp_valid_o afterwards, all sets invalid.

Verification
REQ-030 Post-reset lookup index 0x12 tag 0xABCDE, RAM returns 0xABCDE -> resp_valid_o=1 at N+1, resp_hit_o=0 (valid clear).
REQ-031 Refill index 0x12 tag 0xABCDE, then lookup same -> ram_wr_en_o=1 on refill cycle; lookup resp_hit_o=1; lookup tag 0xABCDF -> resp_hit_o=0.
REQ-032 Same-cycle flush_req_i, rfl_valid_i, lkp_valid_i in IDLE -> flush wins, both readies 0, 256 write cycles index 0..255 tag 0, flush_done_o at cycle 256, then refill accepted.
REQ-033 Refill index 0xFF then flush then lookup 0xFF with matching RAM tag -> resp_hit_o=0.
REQ-034 Assert rst_n=0 at sweep counter 0x80 -> flush_busy_o drops immediately, no flush_done_o, prior refilled sets miss.
REQ-035 Continuous lkp_valid_i -> resp_valid_o every other cycle, lkp_ready_o alternates 1/0.
